// File: rtl/ps2_keyboard_fifo_if.sv
// rtl/ps2_keyboard_fifo_if.sv - host register bus for the PS/2 keyboard FIFO
interface ps2_keyboard_fifo_if;
  logic       cs;
  logic       rd;
  logic [1:0] address;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, rd, address, input dout, irq);
  modport slave  (input cs, rd, address, output dout, irq);
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// rtl/ps2_keyboard_fifo.sv - PS/2 keyboard receiver, scan-code to ASCII decoder and FIFO
// Define PS2_KEYBOARD_LOWERCASE_EN to translate unshifted letters to lowercase.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_clk,
  input  logic                 key_din,
  ps2_keyboard_fifo_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_NORMAL, S_F0, S_E0, S_E0F0} state_t;

  function automatic logic [6:0] letter_of(input logic [7:0] c);
    case (c)
      8'h1C: return 7'h41; 8'h32: return 7'h42; 8'h21: return 7'h43; 8'h23: return 7'h44;
      8'h24: return 7'h45; 8'h2B: return 7'h46; 8'h34: return 7'h47; 8'h33: return 7'h48;
      8'h43: return 7'h49; 8'h3B: return 7'h4A; 8'h42: return 7'h4B; 8'h4B: return 7'h4C;
      8'h3A: return 7'h4D; 8'h31: return 7'h4E; 8'h44: return 7'h4F; 8'h4D: return 7'h50;
      8'h15: return 7'h51; 8'h2D: return 7'h52; 8'h1B: return 7'h53; 8'h2C: return 7'h54;
      8'h3C: return 7'h55; 8'h2A: return 7'h56; 8'h1D: return 7'h57; 8'h22: return 7'h58;
      8'h35: return 7'h59; 8'h1A: return 7'h5A;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] other_of(input logic [7:0] c, input logic sh);
    case (c)
      8'h45: return sh ? 7'h29 : 7'h30; 8'h16: return sh ? 7'h21 : 7'h31;
      8'h1E: return sh ? 7'h40 : 7'h32; 8'h26: return sh ? 7'h23 : 7'h33;
      8'h25: return sh ? 7'h24 : 7'h34; 8'h2E: return sh ? 7'h25 : 7'h35;
      8'h36: return sh ? 7'h5E : 7'h36; 8'h3D: return sh ? 7'h26 : 7'h37;
      8'h3E: return sh ? 7'h2A : 7'h38; 8'h46: return sh ? 7'h28 : 7'h39;
      8'h0E: return sh ? 7'h7E : 7'h60; 8'h4E: return sh ? 7'h5F : 7'h2D;
      8'h55: return sh ? 7'h2B : 7'h3D; 8'h54: return sh ? 7'h7B : 7'h5B;
      8'h5B: return sh ? 7'h7D : 7'h5D; 8'h5D: return sh ? 7'h7C : 7'h5C;
      8'h4C: return sh ? 7'h3A : 7'h3B; 8'h52: return sh ? 7'h22 : 7'h27;
      8'h41: return sh ? 7'h3C : 7'h2C; 8'h49: return sh ? 7'h3E : 7'h2E;
      8'h4A: return sh ? 7'h3F : 7'h2F;
      8'h66: return 7'h08; 8'h5A: return 7'h0D; 8'h29: return 7'h20; 8'h76: return 7'h1B;
      default: return 7'h00;
    endcase
  endfunction

  // Zero means "no character" for unsupported codes.
  function automatic logic [6:0] translate(input logic [7:0] c, input logic sh, input logic ct);
    logic [6:0] lt;
    lt = letter_of(c);
    if (lt != 7'h00) begin
      if (ct) return lt & 7'h1F;
`ifdef PS2_KEYBOARD_LOWERCASE_EN
      return sh ? lt : (lt | 7'h20);
`else
      return lt;
`endif
    end
    return other_of(c, sh);
  endfunction

  logic [1:0]    kc_sync, kd_sync;
  logic          filt, fall, din_s;
  logic [FW-1:0] fcnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic [TW-1:0] idle;
  logic          frame_end, frame_ok, byte_valid, frame_bad;
  logic [7:0]    rx_byte;

  assign din_s = kd_sync[1];
  assign fall  = filt & ~kc_sync[1] & (fcnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kc_sync <= 2'b11;
      kd_sync <= 2'b11;
      filt    <= 1'b1;
      fcnt    <= '0;
    end else begin
      kc_sync <= {kc_sync[0], key_clk};
      kd_sync <= {kd_sync[0], key_din};
      if (kc_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= kc_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      idle    <= '0;
    end else if (fall) begin
      idle    <= '0;
      shreg   <= {din_s, shreg[9:1]};
      bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end else if (bit_cnt != 4'd0) begin
      if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt <= '0;
        idle    <= '0;
      end else begin
        idle <= idle + TW'(1);
      end
    end else begin
      idle <= '0;
    end
  end

  // The stop bit is taken straight from the synchroniser so the byte decodes on its own edge.
  assign frame      = {din_s, shreg};
  assign frame_end  = fall && (bit_cnt == 4'd10);
  assign frame_ok   = !frame[0] && frame[10] && (^frame[9:1]);
  assign byte_valid = frame_end && frame_ok;
  assign frame_bad  = frame_end && !frame_ok;
  assign rx_byte    = frame[8:1];

  state_t     state, state_n;
  logic       lshift, rshift, ctrl, lshift_n, rshift_n, ctrl_n;
  logic       push_req;
  logic [6:0] push_char;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_NORMAL;
      lshift <= 1'b0;
      rshift <= 1'b0;
      ctrl   <= 1'b0;
    end else begin
      state  <= state_n;
      lshift <= lshift_n;
      rshift <= rshift_n;
      ctrl   <= ctrl_n;
    end
  end

  always_comb begin
    state_n   = state;
    lshift_n  = lshift;
    rshift_n  = rshift;
    ctrl_n    = ctrl;
    push_req  = 1'b0;
    push_char = 7'h00;
    if (byte_valid) begin
      state_n = S_NORMAL;
      case (state)
        S_NORMAL: begin
          if (rx_byte == 8'hF0)      state_n = S_F0;
          else if (rx_byte == 8'hE0) state_n = S_E0;
          else if (rx_byte == 8'h12) lshift_n = 1'b1;
          else if (rx_byte == 8'h59) rshift_n = 1'b1;
          else if (rx_byte == 8'h14) ctrl_n = 1'b1;
          else begin
            push_char = translate(rx_byte, lshift | rshift, ctrl);
            push_req  = (push_char != 7'h00);
          end
        end
        S_F0: begin
          if (rx_byte == 8'h12)      lshift_n = 1'b0;
          else if (rx_byte == 8'h59) rshift_n = 1'b0;
          else if (rx_byte == 8'h14) ctrl_n = 1'b0;
        end
        S_E0: begin
          if (rx_byte == 8'hF0)      state_n = S_E0F0;
          else if (rx_byte == 8'h14) ctrl_n = 1'b1;
          else if (rx_byte == 8'h5A) begin
            push_req  = 1'b1;
            push_char = 7'h0D;
          end
        end
        default: begin
          if (rx_byte == 8'h14) ctrl_n = 1'b0;
        end
      endcase
    end
  end

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [6:0]    count_ext;
  logic [4:0]    count5;
  logic          empty, full, rd_data, rd_clr, pop, push, ovf_set;
  logic          overflow, parity_err, irq_r;
  logic [7:0]    dout_r;

  assign empty     = (count == '0);
  assign full      = (count == (AW + 1)'(FIFO_DEPTH));
  assign rd_data   = bus.cs && bus.rd && (bus.address == 2'd0);
  assign rd_clr    = bus.cs && bus.rd && (bus.address == 2'd2);
  assign pop       = rd_data && !empty;
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign count_ext = 7'(count);
  assign count5    = (count_ext > 7'd31) ? 5'd31 : count_ext[4:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      irq_r      <= 1'b0;
      dout_r     <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)     overflow <= 1'b1;
      else if (rd_clr) overflow <= 1'b0;
      if (frame_bad)   parity_err <= 1'b1;
      else if (rd_clr) parity_err <= 1'b0;
      irq_r <= !empty;
      if (bus.cs && bus.rd) begin
        case (bus.address)
          2'd0:    dout_r <= empty ? 8'h00 : {1'b1, mem[rd_ptr]};
          2'd1:    dout_r <= {!empty, overflow, parity_err, count5};
          default: dout_r <= 8'h00;
        endcase
      end
    end
  end

  assign bus.dout = dout_r;
  assign bus.irq  = irq_r;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// tb/tb_ps2_keyboard_fifo.sv - directed self-checking bench for ps2_keyboard_fifo
module tb_ps2_keyboard_fifo;
  localparam int TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_clk = 1'b1;
  logic key_din = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [7:0] d;
  logic [7:0] exp_lower;

  ps2_keyboard_fifo_if bus();

  ps2_keyboard_fifo #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_clk(key_clk), .key_din(key_din), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    else passed++;
  endtask

  task automatic ps2_bit(input logic b);
    key_din = b;
    repeat (8) @(posedge clk);
    key_clk = 1'b0;
    repeat (15) @(posedge clk);
    key_clk = 1'b1;
    repeat (7) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.address = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.address = 2'd0;
    v = bus.dout;
  endtask

  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.address = 2'd0;
`ifdef PS2_KEYBOARD_LOWERCASE_EN
    exp_lower = 8'hE1;
`else
    exp_lower = 8'hC1;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_dout", bus.dout, 8'h00);
    check("reset_irq", {7'd0, bus.irq}, 8'h00);
    bus_read(2'd1, d); check("reset_status", d, 8'h00);

    // single key, read back, irq deasserts
    send_byte(8'h1C, 1'b0);
    check("a_irq", {7'd0, bus.irq}, 8'h01);
    bus_read(2'd1, d); check("a_status", d, 8'h81);
    bus_read(2'd0, d); check("a_data", d, 8'hC1);
    repeat (2) @(negedge clk);
    check("a_irq_fall", {7'd0, bus.irq}, 8'h00);
    bus_read(2'd0, d); check("empty_data", d, 8'h00);

    // shift held across a digit, then released
    send_byte(8'h12, 1'b0); send_byte(8'h1E, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h1E, 1'b0);
    bus_read(2'd1, d); check("shift_status", d, 8'h82);
    bus_read(2'd0, d); check("shift_at", d, 8'hC0);
    bus_read(2'd0, d); check("shift_2", d, 8'hB2);

    // bad parity
    send_byte(8'h1C, 1'b1);
    bus_read(2'd1, d); check("par_status", d, 8'h20);
    bus_read(2'd2, d); check("par_clr_dout", d, 8'h00);
    bus_read(2'd1, d); check("par_cleared", d, 8'h00);

    // overflow
    for (int i = 0; i < 9; i++) send_byte(8'h16, 1'b0);
    bus_read(2'd1, d); check("ovf_status", d, 8'hC8);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d); check($sformatf("ovf_data%0d", i), d, 8'hB1);
    end
    bus_read(2'd1, d); check("ovf_drained", d, 8'h40);
    bus_read(2'd2, d);
    bus_read(2'd1, d); check("ovf_cleared", d, 8'h00);

    // timeout discards a partial frame
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    repeat (TIMEOUT + 20) @(posedge clk);
    send_byte(8'h32, 1'b0);
    bus_read(2'd1, d); check("tmo_status", d, 8'h81);
    bus_read(2'd0, d); check("tmo_data", d, 8'hC2);

    // reset mid-frame
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    send_byte(8'h1C, 1'b0);
    bus_read(2'd1, d); check("rstmid_status", d, 8'h81);
    bus_read(2'd0, d); check("rstmid_data", d, 8'hC1);

    // ctrl, case, keypad enter, ignored E0 make, E0 ctrl
    send_byte(8'h14, 1'b0); send_byte(8'h21, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
    bus_read(2'd0, d); check("ctrl_c", d, 8'h83);
    send_byte(8'h1C, 1'b0);
    bus_read(2'd0, d); check("plain_a", d, exp_lower);
    send_byte(8'h59, 1'b0); send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h59, 1'b0);
    bus_read(2'd0, d); check("shift_a", d, 8'hC1);
    send_byte(8'hE0, 1'b0); send_byte(8'h5A, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
    bus_read(2'd1, d); check("e0_status", d, 8'h81);
    bus_read(2'd0, d); check("kp_enter", d, 8'h8D);
    send_byte(8'hE0, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h21, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
    send_byte(8'h5D, 1'b0);
    bus_read(2'd0, d); check("rctrl_c", d, 8'h83);
    bus_read(2'd0, d); check("backslash", d, 8'hDC);
    bus_read(2'd1, d); check("final_status", d, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
